mac_operand_feeder: RTL

- Upstream stage of the N x N systolic array built from mac_unit tiles.
- Holds operand matrices A and B (8-bit minifloats: 1 sign, 3 exponent, 4 fraction) in a register file loaded through a write port.
- On start, streams row i of A onto west-edge lane i and column j of B onto north-edge lane j, one element per cycle.
- Each lane is skewed by PASS_LAT cycles per hop, so matching operands meet in every tile. Zero is driven outside each lane's window.

---
 rtl/mac_operand_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - skewed A/B operand streamer for an N x N systolic MAC array
// Optional MAC_FEEDER_BT_EN: B writes address B^T so B can be loaded row-major like A.
module mac_operand_feeder #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int PASS_LAT  = 2,
  parameter int DRAIN_CYC = 2*(N-1)*PASS_LAT+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [$clog2(N)-1:0]  wr_col,
  input  logic [DW-1:0]         wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N*DW-1:0]       a_out,
  output logic [N*DW-1:0]       b_out
);

  localparam int L    = N + (N-1)*PASS_LAT;
  localparam int CMAX = (L > DRAIN_CYC) ? L : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX+1);
  localparam int IW   = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     a_q [N][N];
  logic [DW-1:0]     a_d [N][N];
  logic [DW-1:0]     b_q [N][N];
  logic [DW-1:0]     b_d [N][N];
  logic [N*DW-1:0]   a_out_q, a_out_d;
  logic [N*DW-1:0]   b_out_q, b_out_d;
  int                sv;

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign a_out = a_out_q;
  assign b_out = b_out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    a_out_d = '0;
    b_out_d = '0;
    sv      = 0;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          if (!wr_sel) a_d[wr_row][wr_col] = wr_data;
`ifdef MAC_FEEDER_BT_EN
          else         b_d[wr_col][wr_row] = wr_data;
`else
          else         b_d[wr_row][wr_col] = wr_data;
`endif
        end
        if (start) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        if (cnt_q == CW'(L-1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output flops are loaded from the post-write view so a write coincident with start is streamed.
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        sv = int'(cnt_d) - i*PASS_LAT;
        if (sv >= 0 && sv < N) begin
          a_out_d[i*DW +: DW] = a_d[i][sv[IW-1:0]];
          b_out_d[i*DW +: DW] = b_d[sv[IW-1:0]][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule
